// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data BRAM port between NCH requesters.
// Handles byte/half/word loads and stores, alignment errors and a LAT-deep response pipeline.
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       req_we,
  input  logic [2*NCH-1:0]     req_size,
  input  logic [NCH-1:0]       req_signed,
  input  logic [WIDTH*NCH-1:0] req_addr,
  input  logic [WIDTH*NCH-1:0] req_wdata,
  output logic [NCH-1:0]       rsp_valid,
  output logic [NCH-1:0]       rsp_err,
  output logic [WIDTH*NCH-1:0] rsp_rdata,
  output logic [3:0]           dm_we,
  output logic [WIDTH-1:0]     dm_addr,
  output logic [WIDTH-1:0]     dm_wdata,
  input  logic [WIDTH-1:0]     dm_rdata
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           we;
    logic [1:0]     off;
    size_e          size;
    logic           sgn;
    logic           err;
  } slot_t;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id, cand;
  logic           gnt_any;
  logic [WIDTH-1:0] g_addr, g_wdata;
  size_e          g_size;
  logic           g_we, g_sgn, g_err;
  slot_t          slot_d;
  slot_t          pipe_q [LAT];
  slot_t          rs;
  logic [WIDTH-1:0] shifted, ld;

  // Scan from the pointer upward (with wrap); the first valid channel wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = IDW'((32'(ptr_q) + i) % 32'(NCH));
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (!rst) gnt_any = 1'b0;
    req_ready = gnt_any ? (NCH'(1) << gnt_id) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (32'(gnt_id) == 32'(NCH - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_comb begin
    g_addr  = req_addr[gnt_id*WIDTH +: WIDTH];
    g_wdata = req_wdata[gnt_id*WIDTH +: WIDTH];
    g_size  = size_e'(req_size[gnt_id*2 +: 2]);
    g_we    = req_we[gnt_id];
    g_sgn   = req_signed[gnt_id];
    unique case (g_size)
      SZ_BYTE: g_err = 1'b0;
      SZ_HALF: g_err = g_addr[0];
      SZ_WORD: g_err = (g_addr[1:0] != 2'b00);
      default: g_err = 1'b1;
    endcase

    dm_addr = {g_addr[WIDTH-1:2], 2'b00};
    dm_we   = '0;
    if (gnt_any && g_we && !g_err) begin
      unique case (g_size)
        SZ_BYTE: dm_we = 4'b0001 << g_addr[1:0];
        SZ_HALF: dm_we = 4'b0011 << g_addr[1:0];
        default: dm_we = 4'b1111;
      endcase
    end
    unique case (g_size)
      SZ_BYTE: dm_wdata = {4{g_wdata[7:0]}};
      SZ_HALF: dm_wdata = {2{g_wdata[15:0]}};
      default: dm_wdata = g_wdata;
    endcase

    slot_d.vld  = gnt_any;
    slot_d.id   = gnt_id;
    slot_d.we   = g_we;
    slot_d.off  = g_addr[1:0];
    slot_d.size = g_size;
    slot_d.sgn  = g_sgn;
    slot_d.err  = g_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= slot_d;
      for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The last stage lines up with the BRAM data for the same access.
  always_comb begin
    rs      = pipe_q[LAT-1];
    shifted = dm_rdata >> {rs.off, 3'b000};
    unique case (rs.size)
      SZ_BYTE: ld = rs.sgn ? {{(WIDTH-8){shifted[7]}}, shifted[7:0]}
                           : {{(WIDTH-8){1'b0}}, shifted[7:0]};
      SZ_HALF: ld = rs.sgn ? {{(WIDTH-16){shifted[15]}}, shifted[15:0]}
                           : {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: ld = shifted;
    endcase
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    if (rs.vld) begin
      rsp_valid[rs.id] = 1'b1;
      rsp_err[rs.id]   = rs.err;
      if (!rs.we && !rs.err) rsp_rdata[rs.id*WIDTH +: WIDTH] = ld;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one LAT=1 instance with a byte-enable BRAM model,
// one LAT=2 instance with an address-derived read-data model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: NCH=2, LAT=1
  logic [1:0]  a_valid, a_ready, a_we, a_signed, a_rsp_valid, a_rsp_err;
  logic [3:0]  a_size, a_dm_we;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic [31:0] a_dm_addr, a_dm_wdata, a_dm_rdata;

  // Instance B: NCH=2, LAT=2
  logic [1:0]  b_valid, b_ready, b_we, b_signed, b_rsp_valid, b_rsp_err;
  logic [3:0]  b_size, b_dm_we;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;

  dmem_arbiter #(.WIDTH(32), .NCH(2), .LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_size(a_size),
    .req_signed(a_signed), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rdata),
    .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata), .dm_rdata(a_dm_rdata)
  );

  dmem_arbiter #(.WIDTH(32), .NCH(2), .LAT(2)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
    .req_signed(b_signed), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rdata),
    .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_rdata(b_dm_rdata)
  );

  logic [31:0] mem_a [64];
  logic [31:0] a_rd;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (a_dm_we[b]) mem_a[a_dm_addr[7:2]][b*8 +: 8] <= a_dm_wdata[b*8 +: 8];
    a_rd <= mem_a[a_dm_addr[7:2]];
  end
  assign a_dm_rdata = a_rd;

  function automatic logic [31:0] fb(input logic [31:0] ad);
    return {ad[7:0] ^ 8'h80, 8'h7F, 8'hC3, ad[7:0]};
  endfunction

  logic [31:0] b_s1, b_s2;
  always @(posedge clk) begin
    b_s1 <= fb(b_dm_addr);
    b_s2 <= b_s1;
  end
  assign b_dm_rdata = b_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int ch, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    a_valid[ch]           = 1'b1;
    a_we[ch]              = we;
    a_size[ch*2 +: 2]     = sz;
    a_signed[ch]          = sg;
    a_addr[ch*32 +: 32]   = ad;
    a_wdata[ch*32 +: 32]  = wd;
  endtask

  task automatic set_b(input int ch, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    b_valid[ch]           = 1'b1;
    b_we[ch]              = we;
    b_size[ch*2 +: 2]     = sz;
    b_signed[ch]          = sg;
    b_addr[ch*32 +: 32]   = ad;
    b_wdata[ch*32 +: 32]  = wd;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_valid = '0; a_we = '0; a_size = '0; a_signed = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_we = '0; b_size = '0; b_signed = '0; b_addr = '0; b_wdata = '0;
    set_a(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h11111111);
    set_a(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    #3;
    chk("rst_ready",     32'(a_ready),     32'h0);
    chk("rst_dm_we",     32'(a_dm_we),     32'h0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("rst_rsp_err",   32'(a_rsp_err),   32'h0);
    a_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    // Both channels loading continuously: grants alternate starting at ch0.
    set_a(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    set_a(1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(a_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) chk("rr_rsp_valid", 32'(a_rsp_valid), (k % 2 == 0) ? 32'h2 : 32'h1);
      next_cycle();
    end
    a_valid = '0;
    @(negedge clk);
    chk("rr_last_rsp", 32'(a_rsp_valid), 32'h2);
    chk("idle_ready",  32'(a_ready),     32'h0);
    next_cycle();

    set_a(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h80001234);
    @(negedge clk);
    chk("sw_ready", 32'(a_ready), 32'h1);
    chk("sw_we",    32'(a_dm_we), 32'hF);
    chk("sw_addr",  a_dm_addr,    32'h100);
    chk("sw_wdata", a_dm_wdata,   32'h80001234);
    next_cycle();

    set_a(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    @(negedge clk);
    chk("sw_rsp_valid", 32'(a_rsp_valid), 32'h1);
    chk("sw_rsp_err",   32'(a_rsp_err),   32'h0);
    chk("sw_rsp_rdata", a_rdata[31:0],    32'h0);
    chk("lhu_ready",    32'(a_ready),     32'h1);
    chk("lhu_we",       32'(a_dm_we),     32'h0);
    chk("lhu_addr",     a_dm_addr,        32'h100);
    next_cycle();

    set_a(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    @(negedge clk);
    chk("lhu_rsp_valid", 32'(a_rsp_valid), 32'h1);
    chk("lhu_rdata",     a_rdata[31:0],    32'h00008000);
    next_cycle();

    set_a(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
    @(negedge clk);
    chk("lh_rdata", a_rdata[31:0], 32'hFFFF8000);
    chk("sb_we",    32'(a_dm_we),  32'h8);
    chk("sb_addr",  a_dm_addr,     32'h100);
    chk("sb_wdata", a_dm_wdata,    32'hA5A5A5A5);
    next_cycle();

    set_a(0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    @(negedge clk);
    chk("sb_rsp_valid", 32'(a_rsp_valid), 32'h1);
    chk("sb_rsp_rdata", a_rdata[31:0],    32'h0);
    next_cycle();

    set_a(0, 1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF);
    @(negedge clk);
    chk("lb_rdata",      a_rdata[31:0], 32'hFFFFFFA5);
    chk("sw_mis_ready",  32'(a_ready),  32'h1);
    chk("sw_mis_we",     32'(a_dm_we),  32'h0);
    next_cycle();

    a_valid = '0;
    set_a(1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("sw_mis_rsp_valid", 32'(a_rsp_valid), 32'h1);
    chk("sw_mis_rsp_err",   32'(a_rsp_err),   32'h1);
    chk("sw_mis_rdata",     a_rdata[31:0],    32'h0);
    chk("ill_ready",        32'(a_ready),     32'h2);
    chk("ill_we",           32'(a_dm_we),     32'h0);
    next_cycle();

    a_valid = '0;
    set_a(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF);
    @(negedge clk);
    chk("ill_rsp_valid", 32'(a_rsp_valid), 32'h2);
    chk("ill_rsp_err",   32'(a_rsp_err),   32'h2);
    chk("ill_rdata",     a_rdata[63:32],   32'h0);
    chk("sh_we",         32'(a_dm_we),     32'hC);
    chk("sh_wdata",      a_dm_wdata,       32'hBEEFBEEF);
    next_cycle();

    // Grant ch1, then assert reset mid-cycle while its response is visible.
    a_valid = '0;
    set_a(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("pre_rst_ready", 32'(a_ready), 32'h2);
    next_cycle();
    set_a(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678);
    #1;
    chk("pre_rst_rsp", 32'(a_rsp_valid), 32'h2);
    chk("pre_rst_we",  32'(a_dm_we),     32'hF);
    rst = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("async_rdata",     a_rdata[63:32],   32'h0);
    chk("async_dm_we",     32'(a_dm_we),     32'h0);
    chk("async_ready",     32'(a_ready),     32'h0);
    set_a(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    set_a(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(a_ready),     32'h1);
    chk("post_rst_rsp",   32'(a_rsp_valid), 32'h0);
    next_cycle();
    a_valid = '0;
    @(negedge clk);
    chk("post_rst_rsp2", 32'(a_rsp_valid), 32'h1);
    next_cycle();

    // LAT=2: three back-to-back loads from ch1.
    set_b(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("b_g0_ready", 32'(b_ready), 32'h2);
    next_cycle();
    set_b(1, 1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
    @(negedge clk);
    chk("b_g1_ready", 32'(b_ready),     32'h2);
    chk("b_g1_rsp",   32'(b_rsp_valid), 32'h0);
    next_cycle();
    set_b(1, 1'b0, 2'b01, 1'b0, 32'h1A, 32'h0);
    @(negedge clk);
    chk("b_g2_rsp",   32'(b_rsp_valid), 32'h2);
    chk("b_g2_rdata", b_rdata[63:32],   32'h907FC310);
    next_cycle();
    b_valid = '0;
    @(negedge clk);
    chk("b_g3_rsp",   32'(b_rsp_valid), 32'h2);
    chk("b_g3_rdata", b_rdata[63:32],   32'hFFFFFFC3);
    next_cycle();
    @(negedge clk);
    chk("b_g4_rsp",   32'(b_rsp_valid), 32'h2);
    chk("b_g4_rdata", b_rdata[63:32],   32'h0000987F);
    next_cycle();
    @(negedge clk);
    chk("b_g5_rsp",   32'(b_rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
